// File: rtl/swgen_pkg.sv
// Shared types and constants for the switch bounce generator and its LFSR.
package swgen_pkg;

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      BOUNCE_UP = 2'd1,
      HIGH      = 2'd2,
      BOUNCE_DN = 2'd3
   } swgen_state_e;

   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   // One Galois step for x^16+x^14+x^13+x^11+1.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; loads seed on reset, steps every clk.
module lfsr16
   import swgen_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= seed;
      else       q <= lfsr_next(q);
   end

endmodule

// File: rtl/switch_bounce_gen.sv
// Mechanical-contact emulator: turns a clean level into a chattering switch signal.
// Release chatter (BOUNCE_DN) is built only when SWGEN_RELEASE_BOUNCE_EN is defined.
module switch_bounce_gen
   import swgen_pkg::*;
#(
   parameter int unsigned N            = 20,
   parameter int unsigned BOUNCE_TICKS = 3,
   parameter logic [15:0] SEED         = DEFAULT_SEED
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic sw_out,
   output logic busy,
   output logic tick
);

   localparam int unsigned BW = $clog2(BOUNCE_TICKS + 1);
   localparam logic [BW-1:0] BCNT_LOAD = BW'(BOUNCE_TICKS);

   logic          sync_1, cmd;
   logic [N-1:0]  q;
   logic [15:0]   lfsr_q;
   logic          noise;
   swgen_state_e  state_q, state_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          sw_d, busy_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1 <= 1'b0;
         cmd    <= 1'b0;
      end else begin
         sync_1 <= btn_in;
         cmd    <= sync_1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= '0;
      else       q <= q + N'(1);
   end

   assign tick = (q == '0);

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (SEED),
      .q     (lfsr_q)
   );

   // Only bit 0 is the noise source; the mask keeps the whole word referenced.
   assign noise = |(lfsr_q & 16'h0001);

   // Settled states drive their level; bounce states sample noise on ticks.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      sw_d    = sw_out;
      case (state_q)
         LOW: begin
            sw_d = 1'b0;
            if (cmd) begin
               state_d = BOUNCE_UP;
               bcnt_d  = BCNT_LOAD;
            end
         end
         HIGH: begin
            sw_d = 1'b1;
            if (!cmd) begin
`ifdef SWGEN_RELEASE_BOUNCE_EN
               state_d = BOUNCE_DN;
               bcnt_d  = BCNT_LOAD;
`else
               state_d = LOW;
`endif
            end
         end
         BOUNCE_UP: begin
            if (!cmd) begin
`ifdef SWGEN_RELEASE_BOUNCE_EN
               state_d = BOUNCE_DN;
               bcnt_d  = BCNT_LOAD;
`else
               state_d = LOW;
`endif
            end else if (tick) begin
               if (bcnt_q > BW'(1)) begin
                  sw_d   = noise;
                  bcnt_d = bcnt_q - BW'(1);
               end else begin
                  sw_d    = 1'b1;
                  state_d = HIGH;
               end
            end
         end
`ifdef SWGEN_RELEASE_BOUNCE_EN
         BOUNCE_DN: begin
            if (cmd) begin
               state_d = BOUNCE_UP;
               bcnt_d  = BCNT_LOAD;
            end else if (tick) begin
               if (bcnt_q > BW'(1)) begin
                  sw_d   = noise;
                  bcnt_d = bcnt_q - BW'(1);
               end else begin
                  sw_d    = 1'b0;
                  state_d = LOW;
               end
            end
         end
`endif
         default: state_d = LOW;
      endcase
      busy_d = (state_d == BOUNCE_UP) || (state_d == BOUNCE_DN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LOW;
         bcnt_q  <= '0;
         sw_out  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         sw_out  <= sw_d;
         busy    <= busy_d;
      end
   end

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Bench for switch_bounce_gen: window-level reference model plus directed scenarios.
module tb_switch_bounce_gen;

`ifdef SWGEN_RELEASE_BOUNCE_EN
   localparam bit REL_EN = 1'b1;
`else
   localparam bit REL_EN = 1'b0;
`endif
   localparam int unsigned TN = 4;

   logic clk = 1'b0;
   logic reset;
   logic btn_in;
   logic sw0, busy0, tick0, sw1, busy1, tick1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   switch_bounce_gen #(.N(TN), .BOUNCE_TICKS(3), .SEED(16'hACE1)) dut0 (
      .clk(clk), .reset(reset), .btn_in(btn_in), .sw_out(sw0), .busy(busy0), .tick(tick0));

   switch_bounce_gen #(.N(TN), .BOUNCE_TICKS(1), .SEED(16'hACE1)) dut1 (
      .clk(clk), .reset(reset), .btn_in(btn_in), .sw_out(sw1), .busy(busy1), .tick(tick1));

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int bt(input int k);
      return (k == 0) ? 3 : 1;
   endfunction

   // Reference model: settled level, or an open window toward a target with ticks left.
   logic        m_h1, m_h2, m_cmd, m_tk;
   int          m_q;
   logic [15:0] m_lf;
   logic        m_sw[2], m_busy[2], m_L[2], m_mode[2], m_tgt[2];
   int          m_left[2];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_h1 = 0; m_h2 = 0; m_q = 0; m_lf = 16'hACE1;
         for (int k = 0; k < 2; k++) begin
            m_sw[k] = 0; m_busy[k] = 0; m_L[k] = 0; m_mode[k] = 0; m_tgt[k] = 0; m_left[k] = 0;
         end
      end else begin
         m_tk  = (m_q == 0);
         m_cmd = m_h2;
         for (int k = 0; k < 2; k++) begin
            if (!m_mode[k]) begin
               m_sw[k]   = m_L[k];
               m_busy[k] = 0;
               if (m_cmd != m_L[k]) begin
                  if (m_cmd || REL_EN) begin
                     m_mode[k] = 1; m_tgt[k] = m_cmd; m_left[k] = bt(k); m_busy[k] = 1;
                  end else begin
                     m_L[k] = 0;
                  end
               end
            end else if (m_cmd != m_tgt[k]) begin
               if (!m_tgt[k] || REL_EN) begin
                  m_tgt[k] = m_cmd; m_left[k] = bt(k); m_busy[k] = 1;
               end else begin
                  m_mode[k] = 0; m_L[k] = 0; m_busy[k] = 0;
               end
            end else if (m_tk) begin
               if (m_left[k] > 1) begin
                  m_sw[k] = m_lf[0]; m_left[k]--;
               end else begin
                  m_sw[k] = m_tgt[k]; m_L[k] = m_tgt[k]; m_mode[k] = 0; m_busy[k] = 0;
               end
            end
         end
         m_h2 = m_h1;
         m_h1 = btn_in;
         m_q  = (m_q + 1) % (1 << TN);
         m_lf = {1'b0, m_lf[15:1]} ^ (m_lf[0] ? 16'hB400 : 16'h0000);
      end
   end

   always @(negedge clk) begin
      chk("sw0",   16'(sw0),   16'(m_sw[0]));
      chk("busy0", 16'(busy0), 16'(m_busy[0]));
      chk("tick0", 16'(tick0), 16'(m_q == 0));
      chk("sw1",   16'(sw1),   16'(m_sw[1]));
      chk("busy1", 16'(busy1), 16'(m_busy[1]));
      chk("tick1", 16'(tick1), 16'(m_q == 0));
      chk("lfsr",  dut0.u_lfsr.q, m_lf);
   end

   // Runs until dut0's window closes; counts ticks seen inside each window.
   task automatic run_window(input int maxc, output int cyc, output int t0, output int t1);
      cyc = 0; t0 = 0; t1 = 0;
      while (busy0 && cyc < maxc) begin
         if (tick0) t0++;
         if (busy1 && tick1) t1++;
         @(negedge clk);
         cyc++;
      end
      chk("window_timeout", 16'(busy0), 16'd0);
   endtask

   task automatic wait_busy(input int maxc);
      int n = 0;
      while (!busy0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("busy_wait_timeout", 16'(busy0), 16'd1);
   endtask

   int cyc, t0, t1, n;

   initial begin
      btn_in = 0;
      reset  = 1;
      // Reset state
      repeat (5) begin
         @(negedge clk);
         chk("rst_tick", 16'(tick0), 16'd1);
         chk("rst_sw",   16'(sw0),   16'd0);
         chk("rst_busy", 16'(busy0), 16'd0);
      end
      reset = 0;
      #1 chk("seed", dut0.u_lfsr.q, 16'hACE1);
      @(negedge clk);
      chk("lfsr_step1", dut0.u_lfsr.q, 16'hE270);
      chk("tick_off",   16'(tick0), 16'd0);
      @(negedge clk);
      chk("lfsr_step2", dut0.u_lfsr.q, 16'h7138);
      repeat (18) @(negedge clk);

      // Press
      btn_in = 1;
      repeat (2) @(negedge clk);
      chk("press_busy_early", 16'(busy0), 16'd0);
      @(negedge clk);
      chk("press_busy_rise", 16'(busy0), 16'd1);
      run_window(80, cyc, t0, t1);
      chk("press_ticks",  16'(t0), 16'd3);
      chk("press_win_ok", 16'(cyc >= 33 && cyc <= 48), 16'd1);
      chk("press_settle", 16'(sw0), 16'd1);
      chk("bt1_ticks",    16'(t1), 16'd1);
      chk("bt1_settle",   16'(sw1), 16'd1);
      repeat (20) @(negedge clk);

      // Release
      btn_in = 0;
      if (REL_EN) begin
         repeat (3) @(negedge clk);
         chk("rel_busy_rise", 16'(busy0), 16'd1);
         run_window(80, cyc, t0, t1);
         chk("rel_ticks",  16'(t0), 16'd3);
         chk("rel_settle", 16'(sw0), 16'd0);
      end else begin
         repeat (3) @(negedge clk);
         chk("rel_sw_hold", 16'(sw0),   16'd1);
         chk("rel_no_busy", 16'(busy0), 16'd0);
         @(negedge clk);
         chk("rel_sw_low",  16'(sw0),   16'd0);
      end
      repeat (20) @(negedge clk);
      chk("idle_low", 16'(sw0), 16'd0);

      // Reversal after one tick inside the press window
      btn_in = 1;
      wait_busy(6);
      n = 0;
      while (!tick0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rev_tick_seen", 16'(tick0), 16'd1);
      @(negedge clk);
      btn_in = 0;
      repeat (2) @(negedge clk);
      chk("rev_still_up", 16'(busy0), 16'd1);
      @(negedge clk);
      if (REL_EN) begin
         chk("rev_dn_busy", 16'(busy0), 16'd1);
         run_window(80, cyc, t0, t1);
         chk("rev_ticks",  16'(t0), 16'd3);
         chk("rev_settle", 16'(sw0), 16'd0);
      end else begin
         chk("rev_abort_busy", 16'(busy0), 16'd0);
         @(negedge clk);
         chk("rev_abort_sw", 16'(sw0), 16'd0);
      end
      repeat (20) @(negedge clk);

      // Reset in the middle of a press window
      btn_in = 1;
      wait_busy(6);
      repeat (5) @(negedge clk);
      chk("mid_busy", 16'(busy0), 16'd1);
      #2 reset = 1;
      #1;
      chk("mid_rst_sw",   16'(sw0),   16'd0);
      chk("mid_rst_busy", 16'(busy0), 16'd0);
      chk("mid_rst_sw1",  16'(sw1),   16'd0);
      chk("mid_rst_tick", 16'(tick0), 16'd1);
      btn_in = 0;
      repeat (3) @(negedge clk);
      reset = 0;
      repeat (10) @(negedge clk);
      chk("post_rst_sw", 16'(sw0), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
